pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic parametrised pipeline-stage register with a valid/allowin handshake.
//  It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM) with one block.
//  The upstream fields are packed into a single DATA_W payload.
//  It adds what the hand-written stages lack: an optional skid entry that breaks the
//  combinational allowin path, a configurable flush value, and occupancy/flush-drop reporting.
// PARAMETERS
//  DATA_W       64     payload width in bits (packed stage fields)
//  SKID         0      0: single entry, combinational allowin; 1: main+skid, registered allowin
//  CLR_ON_FLUSH 1      1: payload regs load RESET_VAL on flush; 0: payload regs hold their value
//  RESET_VAL    0      DATA_W-bit payload value on reset (and on flush when CLR_ON_FLUSH=1)
//  CNT_W        8      width of the flush-drop counter
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        synchronous reset, active-low
//  flush       in   1        pipeline flush; kills every entry held in the stage
//  hold        in   1        hazard stall (load-use, forward not ready); blocks issue downstream
//  up_valid    in   1        upstream has a valid payload
//  up_allowin  out  1        stage can accept a payload this cycle
//  up_data     in   DATA_W   upstream payload
//  dn_valid    out  1        payload offered downstream
//  dn_allowin  in   1        downstream can accept
//  dn_data     out  DATA_W   payload to downstream (always the main entry)
//  occupancy   out  2        valid entries held: 0..1 when SKID=0, 0..2 when SKID=1
//  flush_drops out  CNT_W    saturating count of valid entries killed by flush
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge) has priority over all else:
//    - main_v=0, skid_v=0, main_d=skid_d=RESET_VAL, flush_drops=0.
//    - Hence dn_valid=0, occupancy=0, dn_data=RESET_VAL.
//    - up_allowin=1 (SKID=0 via the empty-main term; SKID=1 via skid_v=0).
//  - Definitions: up_fire=up_valid&up_allowin; dn_fire=dn_valid&dn_allowin.
//  - dn_valid = main_v & ~hold. dn_data = main_d, registered; there is no up->dn combinational path.
//  - Latency: a payload accepted at edge N is offered downstream from cycle N+1.
//  - SKID=0:
//    - up_allowin = ~main_v | (dn_allowin & ~hold). This is combinational from dn_allowin and hold.
//    - On up_fire: main_d<=up_data, main_v<=1.
//    - Else if dn_fire: main_v<=0.
//    - Else hold state.
//  - SKID=1:
//    - up_allowin = ~skid_v, a registered signal only.
//    - up_fire & main_v & ~dn_fire: skid_d<=up_data, skid_v<=1.
//    - dn_fire & skid_v: main_d<=skid_d, skid_v<=0. A same-cycle up_fire is impossible here.
//    - dn_fire & ~skid_v: main_v<=up_fire; main_d<=up_data if up_fire.
//    - ~main_v & up_fire: main_d<=up_data, main_v<=1. Skid is never filled while main is empty.
//  - hold: keeps the main entry; upstream can still fill an empty main or skid.
//    - With SKID=1 and hold high for 2+ cycles, skid fills and up_allowin drops the next cycle.
//  - Ordering: FIFO order is strict; skid content always leaves after main.
//  - flush (priority below reset, above everything else):
//    - main_v<=0, skid_v<=0.
//    - A same-cycle up_fire payload is discarded, and does not count as dropped.
//    - Payload regs load RESET_VAL when CLR_ON_FLUSH=1, else they keep their value.
//    - flush_drops += main_v+skid_v at that edge, saturating at 2^CNT_W-1, never wrapping.
//    - A same-cycle dn_fire still completes downstream. The entry that fires is still counted
//      as dropped, because flush comes from a later stage and kills the issuing payload.
//  - occupancy = main_v + skid_v.
//    - Invariants: skid_v=1 implies main_v=1; skid_v=1 never occurs when SKID=0.
//  - Reset mid-stall or mid-flush: every entry is cleared and nothing is counted.
// TESTING
//  1. SKID=0: up_data=0xA5 with up_valid=1, dn_allowin=1
//     -> dn_valid=1, dn_data=0xA5 the next cycle; occupancy=1.
//  2. SKID=0: main holds 0x11, hold=1, dn_allowin=1
//     -> dn_valid=0, up_allowin=0; hold=0 -> 0x11 fires, then the next payload loads the same edge.
//  3. SKID=1: dn_allowin=0, send 0x1 then 0x2
//     -> occupancy=2, up_allowin=0; dn_allowin=1 -> 0x1 then 0x2 out in order, up_allowin=1.
//  4. SKID=1, CLR_ON_FLUSH=1: occupancy=2 with flush=1 and up_valid=1
//     -> occupancy=0, dn_data=RESET_VAL, flush_drops=2.
//  5. CNT_W=2: 5 flushes each with main_v=1 -> flush_drops stops at 3, never wraps.
//  6. rst_n=0 while occupancy=2 and hold=1
//     -> next cycle: dn_valid=0, occupancy=0, flush_drops=0, up_allowin=1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-stage register with valid/allowin handshake, optional skid entry,
// flush clearing and a saturating count of entries killed by flush.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int SKID = 0,
  parameter int CLR_ON_FLUSH = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_valid,
  output logic              up_allowin,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_allowin,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);
  logic main_v, skid_v, up_fire, dn_fire;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CNT_W:0] drop_sum;
  assign dn_valid = main_v & ~hold;
  assign dn_fire = dn_valid & dn_allowin;
  // With a skid entry, allowin depends only on registered state
  assign up_allowin = (SKID != 0) ? ~skid_v : (~main_v | (dn_allowin & ~hold));
  assign up_fire = up_valid & up_allowin;
  assign dn_data = main_d;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign drop_sum = {1'b0, flush_drops} + {{CNT_W{1'b0}}, main_v} + {{CNT_W{1'b0}}, skid_v};
  always_ff @(posedge clk)
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
      flush_drops <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      flush_drops <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (CLR_ON_FLUSH != 0) begin
        main_d <= RESET_VAL;
        skid_d <= RESET_VAL;
      end
    end else if (SKID == 0) begin
      if (up_fire) begin
        main_d <= up_data;
        main_v <= 1'b1;
      end else if (dn_fire)
        main_v <= 1'b0;
    end else begin
      if (dn_fire && skid_v) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (dn_fire || !main_v) begin
        main_v <= up_fire;
        if (up_fire) main_d <= up_data;
      end else if (up_fire) begin
        skid_d <= up_data;
        skid_v <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: three stage configurations on shared inputs, each checked against a
// small bounded-FIFO reference model every cycle.
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic rst_n, flush, hold, up_valid, dn_allowin;
  logic [7:0] up_data;
  logic [2:0] ua, dv;
  logic [7:0] dd [3];
  logic [1:0] oc [3];
  logic [7:0] fd0, fd2;
  logic [1:0] fd1;
  int checks = 0, errors = 0;
  int cap [3] = '{1, 2, 2};
  int clr [3] = '{1, 1, 0};
  int maxd [3] = '{255, 3, 255};
  logic [7:0] rv [3] = '{8'h00, 8'h5A, 8'hC3};
  logic [7:0] mq [3][2];
  logic [7:0] head [3];
  int cnt [3], drops [3];
  always #5 clk = ~clk;
  pipe_stage_buf #(.DATA_W(8), .SKID(0), .CLR_ON_FLUSH(1), .RESET_VAL(8'h00), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .up_valid(up_valid), .up_allowin(ua[0]),
    .up_data(up_data), .dn_valid(dv[0]), .dn_allowin(dn_allowin), .dn_data(dd[0]),
    .occupancy(oc[0]), .flush_drops(fd0));
  pipe_stage_buf #(.DATA_W(8), .SKID(1), .CLR_ON_FLUSH(1), .RESET_VAL(8'h5A), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .up_valid(up_valid), .up_allowin(ua[1]),
    .up_data(up_data), .dn_valid(dv[1]), .dn_allowin(dn_allowin), .dn_data(dd[1]),
    .occupancy(oc[1]), .flush_drops(fd1));
  pipe_stage_buf #(.DATA_W(8), .SKID(1), .CLR_ON_FLUSH(0), .RESET_VAL(8'hC3), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .up_valid(up_valid), .up_allowin(ua[2]),
    .up_data(up_data), .dn_valid(dv[2]), .dn_allowin(dn_allowin), .dn_data(dd[2]),
    .occupancy(oc[2]), .flush_drops(fd2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] drops_of(input int i);
    return i == 0 ? {24'd0, fd0} : i == 1 ? {30'd0, fd1} : {24'd0, fd2};
  endfunction
  task automatic model_edge(input int i, input logic r, input logic f, input logic uf, input logic df,
                            input logic [7:0] d);
    if (!r) begin
      cnt[i] = 0;
      head[i] = rv[i];
      drops[i] = 0;
    end else if (f) begin
      drops[i] = (drops[i] + cnt[i] > maxd[i]) ? maxd[i] : drops[i] + cnt[i];
      cnt[i] = 0;
      if (clr[i] != 0) head[i] = rv[i];
    end else begin
      if (df) begin
        mq[i][0] = mq[i][1];
        cnt[i]--;
      end
      if (uf) begin
        mq[i][cnt[i]] = d;
        cnt[i]++;
      end
      if (cnt[i] > 0) head[i] = mq[i][0];
    end
  endtask
  task automatic step(input logic r, input logic f, input logic h, input logic v,
                      input logic [7:0] d, input logic a);
    logic uf [3];
    logic df [3];
    rst_n = r; flush = f; hold = h; up_valid = v; up_data = d; dn_allowin = a;
    #1;
    for (int i = 0; i < 3; i++) begin
      logic allow, dvm;
      allow = (cap[i] == 1) ? (cnt[i] == 0 || (a && !h)) : (cnt[i] < 2);
      dvm = cnt[i] > 0 && !h;
      chk($sformatf("u%0d_allowin", i), {31'd0, ua[i]}, {31'd0, allow});
      chk($sformatf("u%0d_dn_valid", i), {31'd0, dv[i]}, {31'd0, dvm});
      chk($sformatf("u%0d_dn_data", i), {24'd0, dd[i]}, {24'd0, head[i]});
      chk($sformatf("u%0d_occupancy", i), {30'd0, oc[i]}, cnt[i]);
      chk($sformatf("u%0d_flush_drops", i), drops_of(i), drops[i]);
      uf[i] = v && allow;
      df[i] = dvm && a;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, r, f, uf[i], df[i], d);
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0; up_valid = 1'b0; up_data = 8'h00; dn_allowin = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    step(1, 0, 0, 1, 8'hA5, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 1, 8'h11, 0);
    step(1, 0, 1, 1, 8'h22, 1);
    step(1, 0, 0, 1, 8'h22, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 1, 8'h01, 0);
    step(1, 0, 0, 1, 8'h02, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk("skid_full_occ", {30'd0, oc[1]}, 2);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 1, 8'h03, 0);
    step(1, 0, 0, 1, 8'h04, 0);
    step(1, 1, 0, 1, 8'h05, 0);
    chk("flush_clr_data", {24'd0, dd[1]}, 32'h5A);
    step(1, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 1, 8'h40 + 8'(k), 0);
      step(1, 1, 0, 0, 8'h00, 0);
    end
    chk("drops_saturate", {30'd0, fd1}, 3);
    step(1, 0, 1, 1, 8'h07, 0);
    step(1, 0, 1, 1, 8'h08, 0);
    step(0, 0, 1, 0, 8'h00, 0);
    chk("reset_drops", {30'd0, fd1}, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 600; k++)
      step($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
           $urandom_range(3) != 0, 8'($urandom), $urandom_range(2) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
